// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
package serial_adder_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Bit counter must be able to hold values 0..WIDTH.
   function automatic int cnt_width(input int width);
      return (width < 1) ? 1 : $clog2(width + 1);
   endfunction

endpackage

// File: rtl/serial_adder_full_adder_bit.sv
// Single full-adder cell used by the serial adder, one bit per clock.
module full_adder_bit (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, with valid/ready on both sides.
// Optional signed overflow output is enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
`ifdef SERIAL_ADDER_OVF_EN
   output logic             ovf,
`endif
   output logic             busy
);

   localparam int CW = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] sum_sh;
   logic [WIDTH-1:0] sum_nxt;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             fa_s;
   logic             fa_c;
   logic             last_bit;

   full_adder_bit u_fa (
      .a    (a_sh[0]),
      .b    (b_sh[0]),
      .cin  (carry),
      .s    (fa_s),
      .cout (fa_c)
   );

   // New sum bit enters at the MSB; this form also holds for WIDTH=1.
   assign sum_nxt  = (sum_sh >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
   assign last_bit = (cnt == LAST);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (in_valid) begin
               state_nxt = SHIFT;
            end else begin
               state_nxt = IDLE;
            end
         end
         SHIFT: begin
            if (last_bit) begin
               state_nxt = DONE;
            end else begin
               state_nxt = SHIFT;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_nxt = IDLE;
            end else begin
               state_nxt = DONE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         sum       <= '0;
         cout      <= 1'b0;
         carry     <= 1'b0;
         cnt       <= '0;
         a_sh      <= '0;
         b_sh      <= '0;
         sum_sh    <= '0;
      end else begin
         state     <= state_nxt;
         in_ready  <= (state_nxt == IDLE);
         out_valid <= (state_nxt == DONE);
         busy      <= (state_nxt != IDLE);
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_sh  <= a;
                  b_sh  <= b;
                  carry <= cin;
                  cnt   <= '0;
               end
            end
            SHIFT: begin
               carry  <= fa_c;
               sum_sh <= sum_nxt;
               a_sh   <= a_sh >> 1;
               b_sh   <= b_sh >> 1;
               cnt    <= cnt + CW'(1);
               if (last_bit) begin
                  sum  <= sum_nxt;
                  cout <= fa_c;
               end
            end
            default: begin
            end
         endcase
      end
   end

`ifdef SERIAL_ADDER_OVF_EN
   // Carry into the MSB is the carry flop on the last bit; carry out is the cell output.
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf <= 1'b0;
      end else if (state == SHIFT && last_bit) begin
         ovf <= carry ^ fa_c;
      end else begin
         ovf <= ovf;
      end
   end
`endif

endmodule
